// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-access definitions: access-type codes, data width and the memory command payload.
package mem_port_arbiter_pkg;

  localparam int unsigned DWIDTH       = 32;
  localparam int unsigned MEM_TYPE_LEN = 3;
  localparam int unsigned BE_W         = DWIDTH / 8;

  // Access-type codes, shared with the control unit's mem_type (funct3 encoding)
  localparam logic [MEM_TYPE_LEN-1:0] MEM_B  = MEM_TYPE_LEN'(0);
  localparam logic [MEM_TYPE_LEN-1:0] MEM_H  = MEM_TYPE_LEN'(1);
  localparam logic [MEM_TYPE_LEN-1:0] MEM_W  = MEM_TYPE_LEN'(2);
  localparam logic [MEM_TYPE_LEN-1:0] MEM_BU = MEM_TYPE_LEN'(4);
  localparam logic [MEM_TYPE_LEN-1:0] MEM_HU = MEM_TYPE_LEN'(5);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Request presented on the memory port
  typedef struct packed {
    logic              we;
    logic [DWIDTH-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DWIDTH-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store byte enables / data replication, load extract / extend, misalignment check.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [MEM_TYPE_LEN-1:0] req_type_i,
  input  logic [1:0]              req_lane_i,
  input  logic [DWIDTH-1:0]       req_wdata_i,
  output logic [BE_W-1:0]         st_be_o,
  output logic [DWIDTH-1:0]       st_wdata_o,
  output logic                    misaligned_o,
  input  logic [MEM_TYPE_LEN-1:0] rsp_type_i,
  input  logic [1:0]              rsp_lane_i,
  input  logic [DWIDTH-1:0]       rsp_rdata_i,
  output logic [DWIDTH-1:0]       ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Illegal type codes and unnatural alignment are both reported as errors
  always_comb begin
    misaligned_o = 1'b0;
    case (req_type_i)
      MEM_B, MEM_BU: misaligned_o = 1'b0;
      MEM_H, MEM_HU: misaligned_o = req_lane_i[0];
      MEM_W:         misaligned_o = (req_lane_i != 2'b00);
      default:       misaligned_o = 1'b1;
    endcase
  end

  // Store lanes: the width bits of the type select the replication pattern
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = req_wdata_i;
    case (req_type_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << req_lane_i;
        st_wdata_o = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << {req_lane_i[1], 1'b0};
        st_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = req_wdata_i;
      end
    endcase
  end

  // Load extract and sign/zero extension from the lane captured with the request
  always_comb begin
    ld_byte   = rsp_rdata_i[{rsp_lane_i, 3'b000} +: 8];
    ld_half   = rsp_rdata_i[{rsp_lane_i[1], 4'b0000} +: 16];
    ld_data_o = rsp_rdata_i;
    case (rsp_type_i)
      MEM_B:   ld_data_o = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
      MEM_BU:  ld_data_o = {{(DWIDTH-8){1'b0}}, ld_byte};
      MEM_H:   ld_data_o = {{(DWIDTH-16){ld_half[15]}}, ld_half};
      MEM_HU:  ld_data_o = {{(DWIDTH-16){1'b0}}, ld_half};
      default: ld_data_o = rsp_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic, one transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [DWIDTH-1:0]       if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DWIDTH-1:0]       if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [MEM_TYPE_LEN-1:0] d_type_i,
  input  logic [DWIDTH-1:0]       d_addr_i,
  input  logic [DWIDTH-1:0]       d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DWIDTH-1:0]       d_rdata_o,
  output logic                    d_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DWIDTH-1:0]       mem_addr_o,
  output logic [BE_W-1:0]         mem_be_o,
  output logic [DWIDTH-1:0]       mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DWIDTH-1:0]       mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [DWIDTH-1:0] WORD_MASK = ~DWIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        starve_q;
  mem_cmd_t                cmd_q, cmd_d;
  owner_e                  owner_q;
  logic [MEM_TYPE_LEN-1:0] type_q;
  logic [1:0]              lane_q;
  logic                    mem_req_q;
  logic                    if_rvalid_q, d_rvalid_q, d_err_q;
  logic [DWIDTH-1:0]       if_rdata_q, d_rdata_q;

  logic                    fetch_win, data_win, idle;
  logic [BE_W-1:0]         st_be;
  logic [DWIDTH-1:0]       st_wdata, ld_data;
  logic                    misaligned;

  mem_lane_align u_align (
    .req_type_i   (d_type_i),
    .req_lane_i   (d_addr_i[1:0]),
    .req_wdata_i  (d_wdata_i),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .misaligned_o (misaligned),
    .rsp_type_i   (type_q),
    .rsp_lane_i   (lane_q),
    .rsp_rdata_i  (mem_rdata_i),
    .ld_data_o    (ld_data)
  );

  // Arbitration: data wins conflicts unless fetch has been passed over STARVE_LIMIT times
  always_comb begin
    fetch_win = if_req_i & (~d_req_i | (starve_q == CNT_W'(STARVE_LIMIT)));
    data_win  = d_req_i & ~fetch_win;
    idle      = (state_q == S_IDLE) & rst_n;
    if_gnt_o  = idle & fetch_win;
    d_gnt_o   = idle & data_win;
  end

  // Memory command built from the winning requester's inputs in the grant cycle
  always_comb begin
    cmd_d = '0;
    if (fetch_win) begin
      cmd_d.we    = 1'b0;
      cmd_d.addr  = if_addr_i & WORD_MASK;
      cmd_d.be    = 4'b1111;
      cmd_d.wdata = '0;
    end else begin
      cmd_d.we    = d_we_i;
      cmd_d.addr  = d_addr_i & WORD_MASK;
      cmd_d.be    = d_we_i ? st_be : 4'b1111;
      cmd_d.wdata = st_wdata;
    end
  end

  // Transaction FSM, starvation counter and registered responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      cmd_q       <= '0;
      owner_q     <= OWN_IF;
      type_q      <= '0;
      lane_q      <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_gnt_o) begin
            cmd_q     <= cmd_d;
            owner_q   <= OWN_IF;
            mem_req_q <= 1'b1;
            starve_q  <= '0;
            state_q   <= S_REQ;
          end else if (d_gnt_o) begin
            if (if_req_i && (starve_q != CNT_W'(STARVE_LIMIT))) begin
              starve_q <= starve_q + CNT_W'(1);
            end
            if (misaligned) begin
              d_rvalid_q <= 1'b1;
              d_err_q    <= 1'b1;
              d_rdata_q  <= '0;
            end else begin
              cmd_q     <= cmd_d;
              owner_q   <= OWN_D;
              type_q    <= d_type_i;
              lane_q    <= d_addr_i[1:0];
              mem_req_q <= 1'b1;
              state_q   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= S_IDLE;
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata_i;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= cmd_q.we ? '0 : ld_data;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_be_o    = cmd_q.be;
  assign mem_wdata_o = cmd_q.wdata;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;

endmodule
